// File: rtl/seq_frame_tx.sv
// seq_frame_tx -- transmit side of the 2-bit symbol frame interface.
//
// Buffers host symbols in a FIFO and, on start, serialises exactly FRAME_LEN
// cycles of symbols onto tx_valid/tx_data. Pad symbol 2'b10 fills the frame
// once the buffer runs dry. While sending, it runs a model of the receiver's
// state sequence to predict the receiver's answer. It then waits up to TIMEOUT
// cycles for rx_valid/rx_data and reports pass/fail with a one-cycle done.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   wr_valid, wr_data    host symbol write; wr_ready = buffer not full
//   start                one-cycle frame request (ignored while busy or empty)
//   busy                 high from accepted start until done
//   tx_valid, tx_data    frame towards the receiver
//   rx_valid, rx_data    receiver response
//   done                 one-cycle end-of-transaction pulse
//   pass, expected,      result, predicted answer and response-seen flag,
//   resp_seen            valid with done and held until the next done
//                        ("expect" is a reserved word, hence "expected")
//
// Optional build macro SEQ_FRAME_TX_ERRCNT_EN adds err_cnt[7:0], a saturating
// count of failed transactions, cleared by rst or by a start accepted while
// wr_data==2'b11 and wr_valid==0.
module seq_frame_tx #(
   parameter int FRAME_LEN = 20,
   parameter int DEPTH     = 32,
   parameter int TIMEOUT   = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   input  logic [1:0] wr_data,
   output logic       wr_ready,
   input  logic       start,
   output logic       busy,
   output logic       tx_valid,
   output logic [1:0] tx_data,
   input  logic       rx_valid,
   input  logic [1:0] rx_data,
   output logic       done,
   output logic       pass,
   output logic [1:0] expected,
`ifdef SEQ_FRAME_TX_ERRCNT_EN
   output logic [7:0] err_cnt,
`endif
   output logic       resp_seen
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(FRAME_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] PAD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_SEND   = 2'b01,
      S_WAIT   = 2'b10,
      S_REPORT = 2'b11
   } state_t;

   // Receiver model step for a non-terminating symbol. 10 is neutral and
   // state 11 is absorbing; 11 symbols are handled as termination elsewhere.
   function automatic logic [1:0] model_next(input logic [1:0] m, input logic [1:0] sym);
      logic [1:0] r;
      r = m;
      case (sym)
         2'b00: begin
            case (m)
               2'b00:   r = 2'b00;
               2'b01:   r = 2'b00;
               2'b10:   r = 2'b01;
               default: r = m;
            endcase
         end
         2'b01: begin
            case (m)
               2'b00:   r = 2'b01;
               2'b01:   r = 2'b10;
               2'b10:   r = 2'b10;
               default: r = m;
            endcase
         end
         default: r = m;
      endcase
      return r;
   endfunction

   logic [1:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   state_t        state_r;
   logic [SW-1:0] slot_r;
   logic [TW-1:0] tmr_r;
   logic [1:0]    m_r;
   logic          term_r;
   logic [1:0]    exp_r;
   logic          seen_r;
   logic [1:0]    cap_r;

   logic          push_s;
   logic          start_acc_s;
   logic          emit_s;
   logic          pop_s;
   logic [1:0]    sym_s;
   logic [CW-1:0] count_n_s;
   logic          mon_s;
   logic          cap_now_s;
   logic          seen_n_s;
   logic [1:0]    cap_n_s;
   logic          term_hit_s;
   logic          report_s;
   logic          pass_s;

   // Next-state decode shared by the FIFO, the FSM and the optional counter.
   always_comb begin
      push_s      = wr_valid && wr_ready;
      start_acc_s = (state_r == S_IDLE) && start && (count_r != {CW{1'b0}});
      // emit_s marks an edge that loads the next frame symbol onto tx_data
      emit_s      = start_acc_s || ((state_r == S_SEND) && (slot_r < SW'(FRAME_LEN)));
      pop_s       = emit_s && (count_r != {CW{1'b0}});
      if (pop_s) begin
         sym_s = mem_r[rd_ptr_r];
      end else begin
         sym_s = PAD;
      end
      case ({push_s, pop_s})
         2'b10:   count_n_s = count_r + CW'(1);
         2'b01:   count_n_s = count_r - CW'(1);
         default: count_n_s = count_r;
      endcase
      // only the first response of a transaction is kept
      mon_s     = (state_r == S_SEND) || (state_r == S_WAIT);
      cap_now_s = mon_s && rx_valid && !seen_r;
      seen_n_s  = seen_r || cap_now_s;
      if (cap_now_s) begin
         cap_n_s = rx_data;
      end else begin
         cap_n_s = cap_r;
      end
      term_hit_s = (sym_s == 2'b11) && (m_r != 2'b11);
      report_s   = (state_r == S_WAIT) && (seen_n_s || (tmr_r == TW'(TIMEOUT - 1)));
      if (term_r) begin
         pass_s = seen_n_s && (cap_n_s == exp_r);
      end else begin
         pass_s = !seen_n_s;
      end
   end

   // Symbol storage; contents need no reset because count_r gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // FIFO pointers, occupancy and the registered not-full flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         wr_ready <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r  <= count_n_s;
         wr_ready <= (count_n_s != CW'(DEPTH));
      end
   end

   // Transaction FSM with the receiver model and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_IDLE;
         slot_r    <= {SW{1'b0}};
         tmr_r     <= {TW{1'b0}};
         m_r       <= 2'b00;
         term_r    <= 1'b0;
         exp_r     <= 2'b00;
         seen_r    <= 1'b0;
         cap_r     <= 2'b00;
         busy      <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= 2'b00;
         done      <= 1'b0;
         pass      <= 1'b0;
         expected  <= 2'b00;
         resp_seen <= 1'b0;
      end else begin
         done   <= 1'b0;
         seen_r <= seen_n_s;
         cap_r  <= cap_n_s;
         case (state_r)
            S_IDLE: begin
               if (start_acc_s) begin
                  state_r  <= S_SEND;
                  busy     <= 1'b1;
                  slot_r   <= SW'(1);
                  tx_valid <= 1'b1;
                  tx_data  <= sym_s;
                  // first symbol seeds the model; 11 here never terminates
                  m_r      <= sym_s;
                  term_r   <= 1'b0;
                  exp_r    <= 2'b00;
                  seen_r   <= 1'b0;
               end
            end
            S_SEND: begin
               if (emit_s) begin
                  slot_r  <= slot_r + SW'(1);
                  tx_data <= sym_s;
                  if (!term_r) begin
                     if (term_hit_s) begin
                        term_r <= 1'b1;
                        exp_r  <= m_r;
                     end else begin
                        m_r <= model_next(m_r, sym_s);
                     end
                  end
               end else begin
                  state_r  <= S_WAIT;
                  tx_valid <= 1'b0;
                  tx_data  <= 2'b00;
                  tmr_r    <= {TW{1'b0}};
               end
            end
            S_WAIT: begin
               if (report_s) begin
                  state_r   <= S_REPORT;
                  done      <= 1'b1;
                  pass      <= pass_s;
                  expected  <= exp_r;
                  resp_seen <= seen_n_s;
               end else begin
                  tmr_r <= tmr_r + TW'(1);
               end
            end
            S_REPORT: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r  <= S_IDLE;
               busy     <= 1'b0;
               tx_valid <= 1'b0;
               tx_data  <= 2'b00;
            end
         endcase
      end
   end

`ifdef SEQ_FRAME_TX_ERRCNT_EN
   // Saturating count of transactions that ended with pass=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (start_acc_s && (wr_data == 2'b11) && !wr_valid) begin
         err_cnt <= 8'd0;
      end else if (report_s && !pass_s && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: a queue/array model predicts every
// output each cycle, and directed scenarios add hand-computed expectations.
module tb_seq_frame_tx;

   localparam int FRAME_LEN = 20;
   localparam int DEPTH     = 32;
   localparam int TIMEOUT   = 15;
   localparam int P_IDLE    = 0;
   localparam int P_SEND    = 1;
   localparam int P_WAIT    = 2;
   localparam int P_REPORT  = 3;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       wr_valid = 1'b0;
   logic [1:0] wr_data  = 2'b00;
   logic       start    = 1'b0;
   logic       rx_valid = 1'b0;
   logic [1:0] rx_data  = 2'b00;
   logic       wr_ready, busy, tx_valid, done, pass, resp_seen;
   logic [1:0] tx_data, expected;
`ifdef SEQ_FRAME_TX_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   seq_frame_tx #(.FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .start(start), .busy(busy), .tx_valid(tx_valid), .tx_data(tx_data),
      .rx_valid(rx_valid), .rx_data(rx_data), .done(done), .pass(pass),
      .expected(expected),
`ifdef SEQ_FRAME_TX_ERRCNT_EN
      .err_cnt(err_cnt),
`endif
      .resp_seen(resp_seen)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [1:0] q[$];
   logic [1:0] m_frame [FRAME_LEN];
   int         m_phase, m_slot, m_wait;
   bit         m_seen;
   logic [1:0] m_cap;
   logic       e_wr_ready, e_busy, e_tx_valid, e_done, e_pass, e_resp_seen;
   logic [1:0] e_tx_data, e_expect;

   // {terminated, predicted answer} of the recorded frame
   function automatic logic [2:0] predict();
      logic [1:0] m;
      m = m_frame[0];
      for (int i = 1; i < FRAME_LEN; i++) begin
         if (m_frame[i] == 2'b11 && m != 2'b11) return {1'b1, m};
         if (m != 2'b11) begin
            if (m_frame[i] == 2'b00) m = (m == 2'b10) ? 2'b01 : 2'b00;
            else if (m_frame[i] == 2'b01) m = (m == 2'b00) ? 2'b01 : 2'b10;
         end
      end
      return 3'b000;
   endfunction

   task automatic model_reset();
      q.delete();
      m_phase = P_IDLE; m_slot = 0; m_wait = 0; m_seen = 1'b0; m_cap = 2'b00;
      e_wr_ready = 1'b1; e_busy = 1'b0; e_tx_valid = 1'b0; e_tx_data = 2'b00;
      e_done = 1'b0; e_pass = 1'b0; e_expect = 2'b00; e_resp_seen = 1'b0;
   endtask

   task automatic emit_symbol();
      logic [1:0] s;
      s = (q.size() > 0) ? q.pop_front() : 2'b10;
      m_frame[m_slot] = s;
      m_slot++;
      e_tx_valid = 1'b1;
      e_tx_data  = s;
   endtask

   task automatic model_step();
      bit         push;
      logic [2:0] pr;
      push   = wr_valid && (q.size() != DEPTH);
      e_done = 1'b0;
      if ((m_phase == P_SEND || m_phase == P_WAIT) && rx_valid && !m_seen) begin
         m_seen = 1'b1;
         m_cap  = rx_data;
      end
      case (m_phase)
         P_IDLE: if (start && q.size() > 0) begin
            m_phase = P_SEND; m_slot = 0; m_seen = 1'b0;
            emit_symbol();
         end
         P_SEND: if (m_slot < FRAME_LEN) emit_symbol();
                 else begin
                    m_phase = P_WAIT; m_wait = 0;
                    e_tx_valid = 1'b0; e_tx_data = 2'b00;
                 end
         P_WAIT: begin
            m_wait++;
            if (m_seen || m_wait == TIMEOUT) begin
               m_phase     = P_REPORT;
               pr          = predict();
               e_expect    = pr[1:0];
               e_resp_seen = m_seen;
               if (pr[2]) e_pass = m_seen && (m_cap == pr[1:0]);
               else       e_pass = !m_seen;
               e_done      = 1'b1;
            end
         end
         default: m_phase = P_IDLE;
      endcase
      if (push) q.push_back(wr_data);
      e_busy     = (m_phase != P_IDLE);
      e_wr_ready = (q.size() != DEPTH);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // ---------------- compare process ----------------
   bit         chk_en = 1'b0;
   int         txn_cnt = 0;
   logic [1:0] tx_log [256];

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("wr_ready",  8'(wr_ready),  8'(e_wr_ready));
            check("busy",      8'(busy),      8'(e_busy));
            check("tx_valid",  8'(tx_valid),  8'(e_tx_valid));
            check("tx_data",   8'(tx_data),   8'(e_tx_data));
            check("done",      8'(done),      8'(e_done));
            check("pass",      8'(pass),      8'(e_pass));
            check("expect",    8'(expected),  8'(e_expect));
            check("resp_seen", 8'(resp_seen), 8'(e_resp_seen));
            if (tx_valid) begin
               if (txn_cnt < 256) tx_log[txn_cnt] = tx_data;
               txn_cnt++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_sym(input logic [1:0] s);
      wr_valid = 1'b1; wr_data = s;
      step(1);
      wr_valid = 1'b0; wr_data = 2'b00;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse_rx(input logic [1:0] d);
      rx_valid = 1'b1; rx_data = d;
      step(1);
      rx_valid = 1'b0; rx_data = 2'b00;
   endtask

   task automatic wait_tx_low(input string name);
      int n;
      n = 0;
      while (tx_valid && n < 40) begin step(1); n++; end
      check(name, 8'(tx_valid), 8'd0);
   endtask

   task automatic wait_done(input string name, output int lat);
      lat = 0;
      while (!done && lat < 80) begin step(1); lat++; end
      check(name, 8'(done), 8'd1);
   endtask

   int base, lat;

   initial begin
      step(3);
      rst = 1'b0;
      chk_en = 1'b1;
      step(1);
      // reset state
      check("rst_wr_ready", 8'(wr_ready), 8'd1);
      check("rst_busy", 8'(busy), 8'd0);
      check("rst_tx", {5'd0, tx_valid, tx_data}, 8'd0);
      check("rst_result", {3'd0, done, pass, expected, resp_seen}, 8'd0);

      // T1: 00,01,01,11 -> expect 10, reply 10
      base = txn_cnt;
      write_sym(2'b00); write_sym(2'b01); write_sym(2'b01); write_sym(2'b11);
      start_pulse();
      check("t1_busy", 8'(busy), 8'd1);
      wait_tx_low("t1_frame_end");
      step(3); pulse_rx(2'b10);
      wait_done("t1_done", lat);
      check("t1_pass", 8'(pass), 8'd1);
      check("t1_expect", 8'(expected), 8'h2);
      check("t1_resp", 8'(resp_seen), 8'd1);
      check("t1_len", 8'(txn_cnt - base), 8'd20);
      check("t1_sym0", 8'(tx_log[base]), 8'h0);
      check("t1_sym3", 8'(tx_log[base + 3]), 8'h3);
      check("t1_pad4", 8'(tx_log[base + 4]), 8'h2);
      check("t1_pad19", 8'(tx_log[base + 19]), 8'h2);
      step(2);
      check("t1_idle", 8'(busy), 8'd0);

      // T2: 10,00,11 -> expect 01; good reply then wrong reply
      write_sym(2'b10); write_sym(2'b00); write_sym(2'b11);
      start_pulse(); wait_tx_low("t2a_frame_end");
      step(2); pulse_rx(2'b01);
      wait_done("t2a_done", lat);
      check("t2a_pass", 8'(pass), 8'd1);
      check("t2a_expect", 8'(expected), 8'h1);
      step(2);
      write_sym(2'b10); write_sym(2'b00); write_sym(2'b11);
      start_pulse(); wait_tx_low("t2b_frame_end");
      step(2); pulse_rx(2'b00);
      wait_done("t2b_done", lat);
      check("t2b_pass", 8'(pass), 8'd0);
      check("t2b_resp", 8'(resp_seen), 8'd1);
      step(2);

      // T3: 01,00,01 no terminator; timeout, then with an unexpected reply
      write_sym(2'b01); write_sym(2'b00); write_sym(2'b01);
      start_pulse();
      wait_done("t3a_done", lat);
      check("t3a_latency", 8'(lat), 8'd35);
      check("t3a_pass", 8'(pass), 8'd1);
      check("t3a_resp", 8'(resp_seen), 8'd0);
      step(2);
      write_sym(2'b01); write_sym(2'b00); write_sym(2'b01);
      start_pulse(); wait_tx_low("t3b_frame_end");
      step(4); pulse_rx(2'b01);
      wait_done("t3b_done", lat);
      check("t3b_pass", 8'(pass), 8'd0);
      check("t3b_resp", 8'(resp_seen), 8'd1);
      step(2);

      // T4: fill 32 (pattern i&3), 33rd write (11) dropped
      for (int i = 0; i < 33; i++) begin
         wr_valid = 1'b1;
         wr_data  = (i == 32) ? 2'b11 : 2'(i);
         step(1);
      end
      wr_valid = 1'b0; wr_data = 2'b00;
      check("t4_full", 8'(wr_ready), 8'd0);
      base = txn_cnt;
      start_pulse(); step(2);
      check("t4_ready_send", 8'(wr_ready), 8'd1);
      check("t4_tx_send", 8'(tx_valid), 8'd1);
      write_sym(2'b01);
      wait_tx_low("t4_frame_end");
      step(1); pulse_rx(2'b01);
      wait_done("t4_done", lat);
      check("t4_pass", 8'(pass), 8'd1);
      check("t4_expect", 8'(expected), 8'h1);
      check("t4_sym19", 8'(tx_log[base + 19]), 8'h3);
      step(2);
      base = txn_cnt;
      start_pulse();
      wait_done("t4b_done", lat);
      check("t4b_pass", 8'(pass), 8'd0);
      check("t4b_expect", 8'(expected), 8'h1);
      check("t4b_sym0", 8'(tx_log[base]), 8'h0);
      check("t4b_sym11", 8'(tx_log[base + 11]), 8'h3);
      check("t4b_extra", 8'(tx_log[base + 12]), 8'h1);
      check("t4b_pad", 8'(tx_log[base + 13]), 8'h2);
      step(2);

      // T5: start with empty buffer is ignored
      base = txn_cnt;
      start_pulse(); step(5);
      check("t5_busy", 8'(busy), 8'd0);
      check("t5_notx", 8'(txn_cnt - base), 8'd0);

      // T6: start during SEND and start during done are ignored
      for (int i = 0; i < 22; i++) write_sym(2'b00);
      base = txn_cnt;
      start_pulse(); step(5);
      start_pulse();
      wait_done("t6_done", lat);
      check("t6_pass", 8'(pass), 8'd1);
      start = 1'b1; step(1); start = 1'b0;
      step(5);
      check("t6_busy_after", 8'(busy), 8'd0);
      check("t6_len", 8'(txn_cnt - base), 8'd20);
      start_pulse();
      wait_done("t6b_done", lat);
      check("t6b_pass", 8'(pass), 8'd1);
      step(2);

      // T7: reset at frame cycle 7 aborts and drops buffered symbols
      for (int i = 0; i < 25; i++) write_sym(2'b01);
      start_pulse(); step(6);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("t7_tx_drop", 8'(tx_valid), 8'd0);
      check("t7_busy", 8'(busy), 8'd0);
      check("t7_ready", 8'(wr_ready), 8'd1);
      step(2);
      @(posedge clk); #2;
      rst = 1'b0;
      step(1);
      base = txn_cnt;
      start_pulse(); step(5);
      check("t7_empty", 8'(busy), 8'd0);
      check("t7_notx", 8'(txn_cnt - base), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
      $fatal(1);
   end

endmodule
